// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default bit timing, receiver state encoding
// and the majority-vote helper used by the receive filter.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 5208;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Front end of the UART receiver: two-flop synchronizer followed by a 3-deep
// vote shift register whose majority gives a glitch-tolerant line value.
module uart_rx_filter
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic sync_out,
    output logic bit_val
);

    logic       sync1_reg;
    logic       sync2_reg;
    logic [2:0] vote_reg;

    // Everything resets to the idle (high) line level so no false start is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            vote_reg[0] <= 1'b1;
        end else begin
            sync1_reg   <= rx;
            sync2_reg   <= sync1_reg;
            vote_reg[0] <= sync2_reg;
        end
    end

    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_vote
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vote_reg[gi] <= 1'b1;
                end else begin
                    vote_reg[gi] <= vote_reg[gi-1];
                end
            end
        end
    endgenerate

    assign sync_out = sync2_reg;
    assign bit_val  = majority3(vote_reg);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: bit-centre sampling FSM, stop-bit check and one-cycle
// valid / frame-error pulses for the local consumer.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   rx_frame_err,
    output logic                   rx_busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic sync_val;
    logic bit_val;

    rx_state_t              state_reg,   state_next;
    logic [CNT_W-1:0]       cnt_reg,     cnt_next;
    logic [2:0]             bit_idx_reg, bit_idx_next;
    logic [UART_DATA_W-1:0] shift_reg,   shift_next;
    logic [UART_DATA_W-1:0] data_reg,    data_next;
    logic                   valid_reg,   valid_next;
    logic                   err_reg,     err_next;

    uart_rx_filter u_filter (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .sync_out (sync_val),
        .bit_val  (bit_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        err_next     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!sync_val) begin
                    state_next = START;
                end
            end
            START: begin
                // Re-check the start bit at its centre to reject short glitches.
                if (cnt_reg == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = bit_val ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next                = '0;
                    shift_next[bit_idx_reg] = bit_val;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
                if (cnt_reg == BIT_LAST) begin
                    cnt_next  = '0;
                    data_next = shift_reg;
                    if (bit_val) begin
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            BREAK: begin
                cnt_next = '0;
                if (sync_val) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign rx_data      = data_reg;
    assign rx_valid     = valid_reg;
    assign rx_frame_err = err_reg;
    assign rx_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clk/bit: a behavioural 8N1 transmitter
// drives rx and a scoreboard checks every valid / frame-error pulse.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;

    // Scoreboard entry: {frame_err_expected, data}
    logic [8:0] sb_q[$];
    logic       prev_pulse = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // glitch_bit >= 0 inverts that data bit for one clock, well away from its centre.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < CPB; c++) begin
                rx = (i == glitch_bit && c == 3) ? ~d[i] : d[i];
                @(negedge clk);
            end
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb_q.size(), 0);
    endtask

    always @(negedge clk) begin
        logic [8:0] exp;
        if (!rst && (rx_valid || rx_frame_err)) begin
            check("excl", {31'd0, rx_valid & rx_frame_err}, 0);
            check("consec", {31'd0, prev_pulse}, 0);
            if (rx_valid) begin
                check("busy_on_pulse", {31'd0, rx_busy}, 0);
            end
            check("pending", {31'd0, sb_q.size() != 0}, 1);
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                check("data", {24'd0, rx_data}, {24'd0, exp[7:0]});
                check("kind", {30'd0, rx_frame_err, rx_valid}, exp[8] ? 32'd2 : 32'd1);
            end
        end
        prev_pulse <= rx_valid | rx_frame_err;
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, rx_data}, 0);
        check("rst_valid", {31'd0, rx_valid}, 0);
        check("rst_err", {31'd0, rx_frame_err}, 0);
        check("rst_busy", {31'd0, rx_busy}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Clean frame
        sb_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1, -1);
        repeat (2 * CPB) @(negedge clk);
        wait_drain(4 * CPB);

        // Short start glitch: no pulse, back to idle
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        check("glitch_busy", {31'd0, rx_busy}, 1);
        repeat (HALF + 3) @(negedge clk);
        check("glitch_idle", {31'd0, rx_busy}, 0);
        repeat (CPB) @(negedge clk);

        // One-clock glitch inside a data bit
        sb_q.push_back({1'b0, 8'h3C});
        send_frame(8'h3C, 1'b1, 2);
        repeat (2 * CPB) @(negedge clk);
        wait_drain(4 * CPB);

        // Stop bit low, line held low
        sb_q.push_back({1'b1, 8'h5A});
        send_frame(8'h5A, 1'b0, -1);
        repeat (40) @(negedge clk);
        check("break_busy", {31'd0, rx_busy}, 1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("break_release", {31'd0, rx_busy}, 0);
        wait_drain(4 * CPB);
        repeat (CPB) @(negedge clk);

        // Back-to-back frames
        sb_q.push_back({1'b0, 8'h00});
        sb_q.push_back({1'b0, 8'hFF});
        sb_q.push_back({1'b0, 8'h81});
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h81, 1'b1, -1);
        repeat (2 * CPB) @(negedge clk);
        wait_drain(4 * CPB);

        // Asynchronous reset mid-DATA of 0x77
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = (i == 1) ? 1'b1 : 1'b1;
            repeat (CPB) @(negedge clk);
        end
        check("mid_busy", {31'd0, rx_busy}, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_data", {24'd0, rx_data}, 0);
        check("arst_busy", {31'd0, rx_busy}, 0);
        check("arst_valid", {31'd0, rx_valid}, 0);
        check("arst_err", {31'd0, rx_frame_err}, 0);
        @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        sb_q.push_back({1'b0, 8'h12});
        send_frame(8'h12, 1'b1, -1);
        repeat (2 * CPB) @(negedge clk);
        wait_drain(4 * CPB);

        // Random bytes with random idle gaps
        for (int n = 0; n < 256; n++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            sb_q.push_back({1'b0, b});
            send_frame(b, 1'b1, -1);
            repeat ($urandom_range(0, CPB)) @(negedge clk);
        end
        repeat (2 * CPB) @(negedge clk);
        wait_drain(4 * CPB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
